// File: rtl/dqsw_lane_training_ctrl.sv
// Sequential per-lane DQSW delay-line sweep: finds the EARLY->LATE eye transition on each lane in turn.
// Optional DQSW_TRAIN_BACKOFF_EN steps the delay line back by up to BACKOFF_TAPS after a transition.
module dqsw_lane_training_ctrl #(
  parameter int NUM_LANES     = 2,
  parameter int TAP_WIDTH     = 8,
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 4,
  parameter int BACKOFF_TAPS  = 2
) (
  input  logic                           FAB_CLK,
  input  logic                           SYNC_RST,
  input  logic                           START,
  input  logic                           ABORT,
  input  logic [NUM_LANES-1:0]           EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]           EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]           DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]           EYE_MONITOR_CLEAR_FLAGS,
  output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
  output logic [NUM_LANES*TAP_WIDTH-1:0] LANE_TAP,
  output logic [NUM_LANES-1:0]           LANE_PASS,
  output logic                           BUSY,
  output logic                           DONE
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_WIDTH-1:0] LAST_TAP    = TAP_WIDTH'(MAX_TAPS - 1);
  localparam logic [LW-1:0]        LAST_LANE   = LW'(NUM_LANES - 1);
  localparam logic [SW-1:0]        LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

  if (NUM_LANES < 1 || MAX_TAPS < 2 || SETTLE_CYCLES < 1 || BACKOFF_TAPS < 0) begin : g_param_check
    $error("dqsw_lane_training_ctrl: invalid parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_MOVE,
`ifdef DQSW_TRAIN_BACKOFF_EN
    S_BACKOFF,
`endif
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state, state_next;
  logic [TAP_WIDTH-1:0] tap;
  logic                 seen_early;
  logic [LW-1:0]        lane;
  logic [SW-1:0]        settle_cnt;
  logic                 early, late, oor, found, fail;

  assign early = EYE_MONITOR_EARLY[lane];
  assign late  = EYE_MONITOR_LATE[lane];
  assign oor   = DELAY_LINE_OUT_OF_RANGE[lane];
  // seen_early is the registered flag, so the current tap's EARLY never counts toward its own transition
  assign found = seen_early && late && !early;
  assign fail  = !found && (oor || tap == LAST_TAP);

`ifdef DQSW_TRAIN_BACKOFF_EN
  localparam logic [TAP_WIDTH:0] BO_TAPS = (TAP_WIDTH+1)'(BACKOFF_TAPS);
  logic [TAP_WIDTH-1:0] bo_cnt, bo_init;
  assign bo_init = ({1'b0, tap} < BO_TAPS) ? tap : BO_TAPS[TAP_WIDTH-1:0];
`endif

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ABORT) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (START) state_next = S_LOAD;
        S_LOAD:   state_next = S_CLEAR;
        S_CLEAR:  state_next = S_SETTLE;
        S_SETTLE: if (settle_cnt == LAST_SETTLE) state_next = S_SAMPLE;
        S_SAMPLE: begin
`ifdef DQSW_TRAIN_BACKOFF_EN
          if (found)     state_next = S_BACKOFF;
`else
          if (found)     state_next = S_NEXT;
`endif
          else if (fail) state_next = S_NEXT;
          else           state_next = S_MOVE;
        end
        S_MOVE:   state_next = S_CLEAR;
`ifdef DQSW_TRAIN_BACKOFF_EN
        S_BACKOFF: if (bo_cnt <= TAP_WIDTH'(1)) state_next = S_NEXT;
`endif
        S_NEXT:   state_next = (lane == LAST_LANE) ? S_DONE : S_LOAD;
        S_DONE:   if (!START) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    DELAY_LINE_MOVE         = '0;
    DELAY_LINE_LOAD         = '0;
    EYE_MONITOR_CLEAR_FLAGS = '0;
    DELAY_LINE_DIRECTION    = '0;
    BUSY                    = (state != S_IDLE) && (state != S_DONE);
    DONE                    = (state == S_DONE);
    case (state)
      S_LOAD:  DELAY_LINE_LOAD[lane] = 1'b1;
      S_CLEAR: EYE_MONITOR_CLEAR_FLAGS[lane] = 1'b1;
      S_MOVE: begin
        DELAY_LINE_MOVE[lane]      = 1'b1;
        DELAY_LINE_DIRECTION[lane] = 1'b1;
      end
`ifdef DQSW_TRAIN_BACKOFF_EN
      S_BACKOFF: if (bo_cnt != '0) DELAY_LINE_MOVE[lane] = 1'b1;
`endif
      default: ;
    endcase
  end

  // ABORT freezes the datapath so results reflect only completed lanes
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      tap        <= '0;
      seen_early <= 1'b0;
      lane       <= '0;
      settle_cnt <= '0;
      LANE_TAP   <= '0;
      LANE_PASS  <= '0;
`ifdef DQSW_TRAIN_BACKOFF_EN
      bo_cnt     <= '0;
`endif
    end else if (!ABORT) begin
      case (state)
        S_IDLE: if (START) begin
          LANE_PASS <= '0;
          lane      <= '0;
        end
        S_LOAD: begin
          tap        <= '0;
          seen_early <= 1'b0;
        end
        S_CLEAR:  settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + SW'(1);
        S_SAMPLE: begin
          if (early) seen_early <= 1'b1;
          if (found) begin
            LANE_PASS[lane] <= 1'b1;
`ifdef DQSW_TRAIN_BACKOFF_EN
            bo_cnt <= bo_init;
`endif
          end else if (fail) begin
            LANE_PASS[lane]                     <= 1'b0;
            LANE_TAP[lane*TAP_WIDTH +: TAP_WIDTH] <= '1;
          end
        end
        S_MOVE: tap <= tap + TAP_WIDTH'(1);
`ifdef DQSW_TRAIN_BACKOFF_EN
        S_BACKOFF: if (bo_cnt != '0) begin
          tap    <= tap - TAP_WIDTH'(1);
          bo_cnt <= bo_cnt - TAP_WIDTH'(1);
        end
`endif
        S_NEXT: begin
          if (LANE_PASS[lane]) LANE_TAP[lane*TAP_WIDTH +: TAP_WIDTH] <= tap;
          if (lane != LAST_LANE) lane <= lane + LW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dqsw_lane_training_ctrl.md
DQSW_LANE_TRAINING_CTRL -- requirements
Module: dqsw_lane_training_ctrl

Interface
REQ-001: Parameter NUM_LANES, default 2, sets the number of DQSW lanes trained sequentially (lane 0 first).
REQ-002: Parameter TAP_WIDTH, default 8, sets the width of each per-lane tap counter and result.
REQ-003: Parameter MAX_TAPS, default 128, sets the taps swept per lane before failure (2 to 2^TAP_WIDTH).
REQ-004: Parameter SETTLE_CYCLES, default 4, sets the wait between flag clear and eye-monitor sample (at least 1).
REQ-005: Parameter BACKOFF_TAPS, default 2, sets the taps stepped back after a transition (used only with the Configuration macro).
REQ-006: FAB_CLK  input  1  sole clock; all logic is rising-edge.
REQ-007: SYNC_RST  input  1  reset, synchronous and active-high.
REQ-008: START  input  1  one-cycle request to begin training; sampled only in IDLE.
REQ-009: ABORT  input  1  stop training and return to IDLE.
REQ-010: EYE_MONITOR_EARLY / EYE_MONITOR_LATE / DELAY_LINE_OUT_OF_RANGE  input  NUM_LANES each  per-lane IOD status.
REQ-011: DELAY_LINE_MOVE / DELAY_LINE_LOAD / EYE_MONITOR_CLEAR_FLAGS  output  NUM_LANES each  per-lane one-cycle pulses; only the active lane's bit is ever high.
REQ-012: DELAY_LINE_DIRECTION  output  NUM_LANES  1 = increment, 0 = decrement; valid whenever MOVE is high.
REQ-013: LANE_TAP  output  NUM_LANES*TAP_WIDTH  final tap per lane; lane i occupies bits [i*TAP_WIDTH +: TAP_WIDTH].
REQ-014: LANE_PASS  output  NUM_LANES  per-lane pass flag.
REQ-015: BUSY / DONE  output  1 each  BUSY is high in every state except IDLE and DONE; DONE is a level.

Function
REQ-016: The state machine SHALL have the states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, MOVE, BACKOFF, NEXT and DONE.
REQ-017: IDLE SHALL go to LOAD on START=1; in the same cycle it clears LANE_PASS and lane index 0 is selected.
REQ-018: LOAD SHALL pulse DELAY_LINE_LOAD for the active lane for 1 cycle, reset the tap counter and seen_early to 0, then go to CLEAR.
REQ-019: CLEAR SHALL pulse EYE_MONITOR_CLEAR_FLAGS for 1 cycle, then go to SETTLE.
REQ-020: SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-021: SAMPLE SHALL last 1 cycle and set seen_early when EARLY=1 for the active lane.
REQ-022: Transition found: in SAMPLE, seen_early (registered, from an earlier tap) = 1 and the lane's LATE=1 and EARLY=0; LANE_PASS[lane] is set and the next state is BACKOFF with the macro defined, NEXT without it.
REQ-023: Failure: in SAMPLE with no transition found, OUT_OF_RANGE=1 or tap = MAX_TAPS-1; LANE_PASS[lane] is set to 0, LANE_TAP[lane] is set to all ones, and the next state is NEXT.
REQ-024: Otherwise, SAMPLE SHALL go to MOVE; MOVE pulses MOVE with DIRECTION=1 for 1 cycle, increments the tap, then goes to CLEAR.
REQ-025: Per-tap latency SHALL be SETTLE_CYCLES+3 cycles (CLEAR + SETTLE + SAMPLE + MOVE).
REQ-026: NEXT SHALL write LANE_TAP[lane] on pass (LANE_TAP is unchanged on fail) and advance the lane; after lane NUM_LANES-1 it goes to DONE, otherwise to LOAD.
REQ-027: DONE SHALL hold DONE=1 and return to IDLE when START=0; while START=1 it stays in DONE, so a held START cannot retrigger training.
REQ-028: START outside IDLE SHALL be ignored.
REQ-029: ABORT SHALL force IDLE on the next edge from any state, with no further pulses; DONE stays 0 and LANE_PASS and LANE_TAP keep their current values.
REQ-030: If ABORT and START are high together in IDLE, ABORT SHALL win.

Reset
REQ-031: SYNC_RST=1 at a rising edge SHALL force IDLE and clear the tap counter, seen_early, lane index, LANE_TAP, LANE_PASS, BUSY, DONE and all pulse outputs to 0, including mid-sweep.
REQ-032: SYNC_RST SHALL take priority over ABORT and START.

Configuration
REQ-033: Macro DQSW_TRAIN_BACKOFF_EN defined: BACKOFF pulses MOVE with DIRECTION=0 once per cycle for min(BACKOFF_TAPS, tap) cycles, decrementing the tap and never going below 0; it then goes to NEXT, and LANE_TAP records the backed-off tap.
REQ-034: Macro undefined: the BACKOFF state and its logic SHALL not be built; LANE_TAP records the transition tap, and DIRECTION is never 0 while MOVE is high.

Verification
REQ-035: NUM_LANES=2, SETTLE_CYCLES=4, macro off; lane0 EARLY at taps 0-9, LATE from 10; lane1 transition at 3 -> LANE_TAP={3,10}, LANE_PASS=2'b11, DONE=1, 7 cycles per tap.
REQ-036: Macro on, BACKOFF_TAPS=2; lane0 transition at 10; lane1 transition at 1 -> LANE_TAP={0,8}, with 2 decrement pulses for lane0 and 1 for lane1.
REQ-037: Lane0 EARLY never asserts, MAX_TAPS=16 -> LANE_PASS[0]=0, LANE_TAP[0]=8'hFF, 15 MOVE pulses; lane1 is still trained.
REQ-038: OUT_OF_RANGE[0]=1 at tap 5 -> lane0 fails at tap 5 with no further MOVE on lane0.
REQ-039: ABORT at lane1 tap 4 -> IDLE next cycle, DONE=0, LANE_PASS[0] kept; a following START retrains from lane0 and clears LANE_PASS.
REQ-040: SYNC_RST during SETTLE of lane0 tap 6 -> all outputs 0 on the next cycle; START held through DONE -> exactly one training run.
